// File: rtl/framebuffer_writer_if.sv
// framebuffer_writer_if: memory burst port and debug register bus used by framebuffer_writer
//   burst_bus_if  : clk, addr[20:0], cmd, cmd_en, wr_data[63:0], data_mask[7:0], rd_data[63:0], rd_valid
//   debug_bus_if  : clk, addr[15:0], wdata[7:0], we
interface burst_bus_if (input logic clk);
  logic [20:0] addr;
  logic        cmd;
  logic        cmd_en;
  logic [63:0] wr_data;
  logic [7:0]  data_mask;
  logic [63:0] rd_data;
  logic        rd_valid;
  modport master (input clk, output addr, cmd, cmd_en, wr_data, data_mask, input rd_data, rd_valid);
  modport slave (input clk, addr, cmd, cmd_en, wr_data, data_mask, output rd_data, rd_valid);
endinterface

interface debug_bus_if (input logic clk);
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        we;
  modport master (input clk, output addr, wdata, we);
  modport slave (input clk, addr, wdata, we);
endinterface

// File: rtl/framebuffer_writer.sv
// framebuffer_writer: packs 32-bit pixels two per 64-bit word and writes them to PSRAM in 4-word bursts
//   clk, rst_n (async, active low) ; bus: burst_bus_if.master write port ; dbus: debug_bus_if.slave, page 0x04
//   in_valid/in_ready/in_data/in_sof/in_sol/in_field : pixel stream ; busy : words buffered or burst in flight
//   Optional macro FRAMEBUFFER_WRITER_INTERLACE_EN: field-aware line addressing (odd field offset, 2*stride per line)
module framebuffer_writer #(
  parameter int CMD_GAP    = 12,
  parameter int FIFO_WORDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  burst_bus_if.master bus,
  debug_bus_if.slave  dbus,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_sof,
  input  logic        in_sol,
  input  logic        in_field,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_WORDS);
  localparam int GW = $clog2(CMD_GAP + 1);
  localparam int EW = 86;
  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;
  state_t state_q, state_d;
  logic [9:0]  width_s_q, width_q, pix_x_q;
  logic [20:0] start_s_q, line_addr_q, addr_q;
  logic [15:0] stride_s_q, stride_q;
  logic [31:0] hi_q;
  logic        line_open_q, flush_q;
  logic [EW-1:0] mem_q [FIFO_WORDS];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, avail;
  logic [2:0]    len_q;
  logic [1:0]    beat_q;
  logic [GW-1:0] gap_q;
  logic        start, full, acc, keep, ends, close_early, push, pop, launch, full_go, flush_clr, vb;
  logic [9:0]  w_eff, idx, nx;
  logic [8:0]  wi;
  logic [20:0] sof_la, new_la, la_eff, paddr;
  logic [31:0] px, push_hi, push_lo;
  logic        lowinv;
  logic [EW-1:0] head;
  logic        unused;
  assign unused = ^{in_field, in_data[31:24], bus.clk, bus.rd_data, bus.rd_valid, dbus.clk};
  assign px = {8'd0, in_data[23:0]};
  assign start = in_sof | in_sol;
  assign full = cnt_q == (AW+1)'(FIFO_WORDS);
  // a line start may not enter until the previous line is closed and flushed
  assign in_ready = rst_n && !full && !(in_valid && start && (flush_q || line_open_q));
  assign acc = in_valid && in_ready;
  assign close_early = in_valid && start && line_open_q && !full;
`ifdef FRAMEBUFFER_WRITER_INTERLACE_EN
  assign sof_la = start_s_q + (in_field ? {5'd0, stride_s_q} : 21'd0);
  assign new_la = in_sof ? sof_la : line_addr_q + {4'd0, stride_q, 1'b0};
`else
  assign sof_la = start_s_q;
  assign new_la = in_sof ? sof_la : line_addr_q + {5'd0, stride_q};
`endif
  // the sof beat already runs with the freshly committed shadow width
  assign w_eff = in_sof ? width_s_q : width_q;
  assign la_eff = start ? new_la : line_addr_q;
  assign idx = start ? 10'd0 : pix_x_q;
  assign nx = idx + 10'd1;
  assign keep = acc && (start ? w_eff != 10'd0 : line_open_q);
  assign ends = keep && nx == w_eff;
  assign push = (keep && (idx[0] || ends)) || (close_early && pix_x_q[0]);
  assign push_hi = (keep && !idx[0]) ? px : hi_q;
  assign push_lo = (keep && idx[0]) ? px : 32'd0;
  assign lowinv = !(keep && idx[0]);
  assign wi = keep ? idx[9:1] : pix_x_q[9:1];
  assign paddr = (keep ? la_eff : line_addr_q) + {10'd0, wi, 2'b00};
  assign head = mem_q[rp_q];
  // count the word pushed this beat so cmd_en can follow the completing beat directly
  assign avail = cnt_q + {{AW{1'b0}}, push};
  assign full_go = avail >= (AW+1)'(4);
  assign launch = state_q == IDLE && gap_q == '0 && (full_go || (flush_q && cnt_q != '0));
  assign flush_clr = state_q == IDLE && flush_q && cnt_q == '0;
  assign vb = {1'b0, beat_q} < len_q;
  assign pop = state_q != IDLE && vb;
  assign busy = cnt_q != '0 || state_q != IDLE;
  assign bus.addr = addr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      width_s_q  <= 10'd256;
      start_s_q  <= '0;
      stride_s_q <= 16'd1024;
    end else if (dbus.we && dbus.addr[15:8] == 8'h04)
      case (dbus.addr[7:0])
        8'd0:    width_s_q[7:0]    <= dbus.wdata;
        8'd1:    width_s_q[9:8]    <= dbus.wdata[1:0];
        8'd7:    start_s_q[7:0]    <= dbus.wdata;
        8'd8:    start_s_q[15:8]   <= dbus.wdata;
        8'd9:    start_s_q[20:16]  <= dbus.wdata[4:0];
        8'd16:   stride_s_q[7:0]   <= dbus.wdata;
        8'd17:   stride_s_q[15:8]  <= dbus.wdata;
        default: ;
      endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      width_q     <= 10'd256;
      stride_q    <= 16'd1024;
      line_addr_q <= '0;
      pix_x_q     <= '0;
      hi_q        <= '0;
      line_open_q <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      if (acc && start) begin
        line_addr_q <= new_la;
        if (in_sof) begin
          width_q  <= width_s_q;
          stride_q <= stride_s_q;
        end
      end
      if (keep) begin
        pix_x_q <= nx;
        if (!idx[0]) hi_q <= px;
      end
      if (close_early || ends) begin
        line_open_q <= 1'b0;
        flush_q     <= 1'b1;
      end else begin
        if (keep && start) line_open_q <= 1'b1;
        if (flush_clr) flush_q <= 1'b0;
      end
    end
  always_ff @(posedge clk)
    if (push) mem_q[wp_q] <= {paddr, push_hi, push_lo, lowinv};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      gap_q  <= '0;
      len_q  <= '0;
      beat_q <= '0;
      addr_q <= '0;
    end else begin
      wp_q   <= wp_q + AW'(push);
      rp_q   <= rp_q + AW'(pop);
      cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      gap_q  <= launch ? GW'(CMD_GAP - 1) : gap_q - GW'(gap_q != '0);
      len_q  <= launch ? (full_go ? 3'd4 : cnt_q[2:0]) : len_q;
      beat_q <= launch ? 2'd0 : state_q != IDLE ? beat_q + 2'd1 : beat_q;
      addr_q <= launch ? head[85:65] : addr_q;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = launch ? CMD : IDLE;
      CMD:     state_d = DATA;
      DATA:    state_d = beat_q == 2'd3 ? IDLE : DATA;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    bus.cmd_en    = state_q == CMD;
    bus.cmd       = state_q == CMD;
    bus.wr_data   = (state_q != IDLE && vb) ? head[64:1] : 64'd0;
    bus.data_mask = state_q == IDLE ? 8'h00 : !vb ? 8'hFF : head[0] ? 8'h0F : 8'h00;
  end
endmodule

// File: tb/tb_framebuffer_writer.sv
// tb_framebuffer_writer: directed test of framebuffer_writer packing, masking, addressing, spacing and reset
module tb_framebuffer_writer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  burst_bus_if bus (.clk(clk));
  debug_bus_if dbus (.clk(clk));
  logic        in_valid = 1'b0, in_ready, in_sof = 1'b0, in_sol = 1'b0, in_field = 1'b0, busy;
  logic [31:0] in_data = '0;
  framebuffer_writer #(.CMD_GAP(12), .FIFO_WORDS(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbus(dbus),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_sof(in_sof), .in_sol(in_sol), .in_field(in_field), .busy(busy)
  );
  int checks = 0, errors = 0, cyc = 0, rem = 0;
  logic [20:0] b_addr [$];
  int          b_time [$];
  logic [63:0] w_data [$];
  logic [7:0]  w_mask [$];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (!rst_n) rem = 0;
    else begin
      if (bus.cmd_en) begin
        b_addr.push_back(bus.addr);
        b_time.push_back(cyc);
        rem = 4;
      end
      if (rem > 0) begin
        w_data.push_back(bus.wr_data);
        w_mask.push_back(bus.data_mask);
        rem--;
      end
    end
  function automatic logic [31:0] pix(input int l, input int x);
    return 32'(l * 4096 + x);
  endfunction
  function automatic logic [63:0] wd(input int l, input int x);
    return {pix(l, x), pix(l, x + 1)};
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  task automatic wr_reg(input logic [7:0] idx, input logic [7:0] v);
    dbus.addr = {8'h04, idx};
    dbus.wdata = v;
    dbus.we = 1'b1;
    @(negedge clk);
    dbus.we = 1'b0;
  endtask
  task automatic send(input logic [31:0] d, input logic sof, input logic sol, output int st);
    logic ok;
    ok = 1'b0;
    st = 0;
    in_data = d;
    in_sof = sof;
    in_sol = sol;
    in_valid = 1'b1;
    for (int i = 0; i < 3000 && !ok; i++) begin
      #4;
      ok = in_ready;
      @(negedge clk);
      if (!ok) st++;
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_sol = 1'b0;
    chk("pixel_accept", {63'd0, ok}, 64'd1);
  endtask
  task automatic send_line(input int n, input int l, input logic sof, output int stalls);
    int st;
    stalls = 0;
    for (int x = 0; x < n; x++) begin
      send(pix(l, x), sof && x == 0, !sof && x == 0, st);
      stalls += st;
    end
  endtask
  task automatic wait_done(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (b_addr.size() >= n && rem == 0 && !busy) break;
      @(negedge clk);
    end
    chk("burst_count", 64'(b_addr.size()), 64'(n));
  endtask
  task automatic clear_q();
    b_addr.delete();
    b_time.delete();
    w_data.delete();
    w_mask.delete();
  endtask
  int st, stalls, t_acc, mingap, nb;
  initial begin
    bus.rd_data = '0;
    bus.rd_valid = 1'b0;
    dbus.addr = '0;
    dbus.wdata = '0;
    dbus.we = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_en", {63'd0, bus.cmd_en}, 64'd0);
    chk("rst_cmd", {63'd0, bus.cmd}, 64'd0);
    chk("rst_addr", 64'(bus.addr), 64'd0);
    chk("rst_wr_data", bus.wr_data, 64'd0);
    chk("rst_mask", 64'(bus.data_mask), 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    // full 8-pixel line: one burst at 0, no masking, cmd_en right after the 8th pixel
    wr_reg(8'd0, 8'd8);
    wr_reg(8'd1, 8'd0);
    clear_q();
    send_line(8, 0, 1'b1, stalls);
    t_acc = cyc;
    wait_done(1, 200);
    chk("t1_latency", 64'(b_time[0]), 64'(t_acc));
    chk("t1_addr", 64'(b_addr[0]), 64'd0);
    for (int w = 0; w < 4; w++) begin
      chk($sformatf("t1_word%0d", w), w_data[w], {32'(2 * w), 32'(2 * w + 1)});
      chk($sformatf("t1_mask%0d", w), 64'(w_mask[w]), 64'h00);
    end
    chk("t1_busy_idle", {63'd0, busy}, 64'd0);
    // width 6 at 0x100: three real words then one padding word
    wr_reg(8'd0, 8'd6);
    wr_reg(8'd8, 8'h01);
    clear_q();
    send_line(6, 1, 1'b1, stalls);
    wait_done(1, 200);
    chk("t2_addr", 64'(b_addr[0]), 64'h100);
    chk("t2_word0", w_data[0], 64'h00001000_00001001);
    chk("t2_word2", w_data[2], 64'h00001004_00001005);
    chk("t2_mask2", 64'(w_mask[2]), 64'h00);
    chk("t2_mask3", 64'(w_mask[3]), 64'hFF);
    // width 5: last word carries only its high pixel
    wr_reg(8'd0, 8'd5);
    clear_q();
    send_line(5, 2, 1'b1, stalls);
    wait_done(1, 200);
    chk("t3_addr", 64'(b_addr[0]), 64'h100);
    chk("t3_word1", w_data[1], 64'h00002002_00002003);
    chk("t3_word2_hi", 64'(w_data[2][63:32]), 64'h2004);
    chk("t3_mask1", 64'(w_mask[1]), 64'h00);
    chk("t3_mask2", 64'(w_mask[2]), 64'h0F);
    chk("t3_mask3", 64'(w_mask[3]), 64'hFF);
    // early in_sol after 3 pixels flushes, next line at +stride
    wr_reg(8'd0, 8'd8);
    wr_reg(8'd8, 8'h00);
    clear_q();
    send_line(3, 3, 1'b1, stalls);
    send_line(8, 4, 1'b0, stalls);
    wait_done(2, 400);
    chk("t4_sol_stalled", {63'd0, stalls > 0}, 64'd1);
    chk("t4_addr0", 64'(b_addr[0]), 64'd0);
    chk("t4_word0", w_data[0], 64'h00003000_00003001);
    chk("t4_word1_hi", 64'(w_data[1][63:32]), 64'h3002);
    chk("t4_mask0", 64'(w_mask[0]), 64'h00);
    chk("t4_mask1", 64'(w_mask[1]), 64'h0F);
    chk("t4_mask2", 64'(w_mask[2]), 64'hFF);
    chk("t4_mask3", 64'(w_mask[3]), 64'hFF);
    chk("t4_addr1", 64'(b_addr[1]), 64'd1024);
    chk("t4_l2_word0", w_data[4], 64'h00004000_00004001);
    chk("t4_l2_word3", w_data[7], 64'h00004006_00004007);
    chk("t4_l2_mask3", 64'(w_mask[7]), 64'h00);
    // field flag: only honoured by the interlaced build
    clear_q();
    in_field = 1'b1;
    send_line(8, 5, 1'b1, stalls);
    in_field = 1'b0;
    send_line(8, 6, 1'b0, stalls);
    wait_done(2, 400);
`ifdef FRAMEBUFFER_WRITER_INTERLACE_EN
    chk("t5_addr0", 64'(b_addr[0]), 64'd1024);
    chk("t5_addr1", 64'(b_addr[1]), 64'd3072);
`else
    chk("t5_addr0", 64'(b_addr[0]), 64'd0);
    chk("t5_addr1", 64'(b_addr[1]), 64'd1024);
`endif
    chk("t5_word0", w_data[0], 64'h00005000_00005001);
    // width 0: everything discarded
    wr_reg(8'd0, 8'd0);
    clear_q();
    send_line(4, 7, 1'b1, stalls);
    repeat (30) @(negedge clk);
    chk("t6_no_burst", 64'(b_addr.size()), 64'd0);
    chk("t6_busy", {63'd0, busy}, 64'd0);
    // 3 lines of 256 pixels under backpressure
    wr_reg(8'd0, 8'd0);
    wr_reg(8'd1, 8'd1);
    clear_q();
    nb = 0;
    for (int l = 0; l < 3; l++) begin
      send_line(256, 16 + l, l == 0, st);
      nb += st;
    end
    wait_done(96, 20000);
    chk("t7_backpressure", {63'd0, nb > 0}, 64'd1);
    mingap = 1000000;
    for (int j = 1; j < b_time.size(); j++)
      if (b_time[j] - b_time[j-1] < mingap) mingap = b_time[j] - b_time[j-1];
    chk("t7_min_spacing_ge12", {63'd0, mingap >= 12}, 64'd1);
    for (int j = 0; j < 96; j++) begin
      chk($sformatf("t7_addr%0d", j), 64'(b_addr[j]), 64'((j / 32) * 1024 + (j % 32) * 16));
      for (int w = 0; w < 4; w++) begin
        chk($sformatf("t7_b%0d_w%0d", j, w), w_data[j*4+w], wd(16 + j / 32, 2 * ((j % 32) * 4 + w)));
        chk($sformatf("t7_b%0d_m%0d", j, w), 64'(w_mask[j*4+w]), 64'h00);
      end
    end
    // reset in the middle of a burst
    wr_reg(8'd0, 8'd8);
    wr_reg(8'd1, 8'd0);
    send_line(8, 8, 1'b1, stalls);
    for (int i = 0; i < 50 && !bus.cmd_en; i++) @(negedge clk);
    chk("t8_burst_started", {63'd0, bus.cmd_en}, 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t8_rst_cmd_en", {63'd0, bus.cmd_en}, 64'd0);
    chk("t8_rst_wr_data", bus.wr_data, 64'd0);
    chk("t8_rst_mask", 64'(bus.data_mask), 64'd0);
    chk("t8_rst_addr", 64'(bus.addr), 64'd0);
    chk("t8_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_q();
    repeat (30) @(negedge clk);
    chk("t8_no_burst_after", 64'(b_addr.size()), 64'd0);
    chk("t8_busy_after", {63'd0, busy}, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/framebuffer_writer.md
# framebuffer_writer

Write-side counterpart of the framebuffer scan-out path. Accepts a stream of 32-bit pixels (0x00RRGGBB or 0x00YYUUVV), packs two pixels per 64-bit word and issues 4-word write bursts over `burst_bus_if` into PSRAM. Pixels are placed at `start_addr + line*stride`, in the word layout the scan-out reader expects. It sits between a pixel source (capture, blitter, test-pattern generator) and the memory arbiter.

## Interface
- `CMD_GAP`, default 12: minimum number of cycles from one `cmd_en` pulse to the next.
- `FIFO_WORDS`, default 16: depth of the 64-bit word FIFO. Must be a power of two, at least 8.

Ports:
- `clk` input 1: single clock for the block. Same net as `bus.clk`.
- `rst_n` input 1: asynchronous, active-low reset.
- `bus` `burst_bus_if.master`: memory write port. The block drives `addr`, `cmd`, `cmd_en`, `wr_data` and `data_mask`, and ignores the read signals.
- `dbus` `debug_bus_if.slave`: register writes, page `addr[15:8]==8'h04`.
- `in_valid` input 1: pixel valid.
- `in_ready` output 1: pixel accepted when `in_valid && in_ready`.
- `in_data` input 32: pixel; bits [31:24] are ignored.
- `in_sof` input 1: qualifies the first pixel of a frame.
- `in_sol` input 1: qualifies the first pixel of a line.
- `in_field` input 1: odd field flag, sampled with `in_sof`. Used only with the interlace feature enabled.
- `busy` output 1: high while any word is buffered or a burst is in flight.

## Operation
- Registers on page 0x04 (index `addr[7:0]`):
  - 0/1: `width[9:0]`, default 256.
  - 7/8/9: `start_addr[20:0]`, default 0.
  - 16/17: `stride[15:0]`, default 1024.
  - Register writes are shadowed and take effect at the next accepted `in_sof`.
- Packing:
  - Even pixel of a line goes to `[63:32]`, odd pixel to `[31:0]`.
  - Each completed word is pushed to the FIFO.
- Line position and addressing:
  - `pix_x` counts accepted pixels in the line.
  - Pixels with `pix_x >= width` are accepted and discarded.
  - `in_sof` loads `line_addr = start_addr`; it has priority over `in_sol` in the same beat.
  - `in_sol` without `in_sof` sets `line_addr += stride`. The first line of a frame uses `start_addr`.
  - Burst address is `line_addr + 16*burst_index_in_line`. Each 64-bit word advances the address by 4.
- Line end:
  - Reached when `pix_x == width`, or when `in_sol`/`in_sof` arrives early.
  - Any half-filled word is pushed with its low half marked invalid.
  - A partial burst is then flushed.
- State machine:
  - IDLE → CMD when (FIFO holds ≥4 words, or a flush is pending) and the gap counter is 0.
  - CMD: `cmd_en=1`, `cmd=1`, `wr_data` = word0; gap counter loads `CMD_GAP-1`.
  - DATA: words 1..3 on the next three cycles, then back to IDLE.
  - No ready signal exists; the controller accepts `cmd_en` whenever spacing is met.
- Byte masks (`data_mask` bit set = byte not written, bit 7 ↔ `[63:56]`):
  - Padding words in a flush burst: 8'hFF.
  - Word whose low pixel is invalid: 8'h0F.
  - Otherwise 8'h00.
- Backpressure: `in_ready = 0` when the FIFO is full, or while a line-end flush is pending and the next line's first pixel is offered.

## Timing
- Reset values: `cmd_en=0`, `cmd=0`, `addr=0`, `wr_data=0`, `data_mask=0`, `busy=0`. `in_ready` is 0 during reset and 1 on the first cycle after release.
- Latency: the earliest `cmd_en` is 1 cycle after the beat that completes the 4th buffered word (8th pixel).
- A burst occupies exactly 4 consecutive cycles. A FIFO pop occurs on each of those cycles.
- A push and a pop in the same cycle leave the occupancy unchanged.
- Gap counter: starts at 0 after reset and decrements to 0 every cycle, including during DATA.
- Reset asserted mid-burst aborts immediately: outputs return to reset values and the FIFO is emptied. The truncated burst is the memory controller's concern.
- Line with `width == 0`: all pixels are discarded and no burst is issued.

## Configuration
- `FRAMEBUFFER_WRITER_INTERLACE_EN` defined:
  - `in_sof` loads `line_addr = start_addr + (in_field ? stride : 0)`.
  - Each `in_sol` adds `2*stride`.
- Macro undefined: `in_field` is ignored and lines advance by `stride`.

## Test plan
- Reset, then write `width=8`; frame of 1 line, pixels 0..7 = 0x000000nn → one burst at addr 0, words 0x00000000_00000001 … 0x00000006_00000007, mask 8'h00 each.
- `width=6`, `start_addr=0x100` → one burst at 0x100; word2 = pixels 4,5; word3 mask 8'hFF.
- `width=5` → word2 mask 8'h0F, word3 mask 8'hFF.
- `width=256`, `stride=1024`, 3 lines, `CMD_GAP=12` → bursts at 0,16,…,496, then 1024…, then 2048…; `cmd_en` spacing ≥12 cycles; `in_ready` drops when the FIFO is full and no pixel is lost.
- `in_sol` after 3 pixels with `width=8` → flush burst of word0 = p0,p1, word1 = p2 with mask 8'h0F, words 2/3 masked 8'hFF; next line starts at `line_addr+stride`.
- With `FRAMEBUFFER_WRITER_INTERLACE_EN`, `in_field=1`, `stride=1024` → first line at 1024, second at 3072.
